mux4_to_1: RTL and testbench
============================

Name: mux4_to_1

Overview:
- 4-to-1 data selector with combinational output plus a registered copy for timing-critical consumers.
- Select is two single-bit lines, s1 = MSB and s0 = LSB.
- Leaf datapath block used wherever one of four sources must be steered onto one net.

Parameters:
- WIDTH, 1, bit width of each data input and each data output.

Ports:
- clk, input, 1, system clock; rising edge active.
- rst_n, input, 1, asynchronous active-low reset.
- d0, input, WIDTH, data input selected when {s1,s0}=2'b00.
- d1, input, WIDTH, data input selected when {s1,s0}=2'b01.
- d2, input, WIDTH, data input selected when {s1,s0}=2'b10.
- d3, input, WIDTH, data input selected when {s1,s0}=2'b11.
- s0, input, 1, select LSB.
- s1, input, 1, select MSB.
- en, input, 1, load enable for the registered output.
- out, output, WIDTH, combinational selected data.
- out_q, output, WIDTH, registered selected data.

Interface constraints:
- One clock; reset is asynchronous and active-low.
- Data/select port order after clk/rst_n is fixed: d0, d1, d2, d3, s0, s1, then en, out, out_q.

Behaviour:
- out = d[{s1,s0}], purely combinational, zero cycles of latency; independent of clk, rst_n and en.
- Select decode: 00→d0, 01→d1, 10→d2, 11→d3.
- X/Z on either select bit: out is X in simulation. No priority fallback.
- out_q is a flop bank clocked on the rising edge of clk.
  - rst_n low: out_q = 0 immediately (asynchronous), held while rst_n is low.
  - rst_n high, en=1 at a rising edge: out_q takes the value of out sampled at that edge (latency 1 cycle).
  - rst_n high, en=0: out_q holds.
- Reset deassertion is synchronised externally. The first load occurs at the first rising edge with rst_n high and en=1.
- Reset mid-operation: out_q clears at once; out continues to track its inputs.
- Select change and data change in the same cycle: out_q captures the new selection with the new data present at the edge.
- No state machine; no arithmetic. All outputs are exactly WIDTH bits, with no extension or truncation.

Optional Feature:
- Macro MUX4_TO_1_PARITY_EN.
- Defined:
  - Adds output par_q (1 bit) = even parity (XOR reduction) of the value loaded into out_q.
  - par_q updates under the same en/reset rules as out_q; reset value 0.
- Undefined:
  - par_q port is absent; no parity logic is synthesised.

Decomposition:
- Package mux4_to_1_pkg holds:
  - Select encodings: SEL_D0=2'b00, SEL_D1=2'b01, SEL_D2=2'b10, SEL_D3=2'b11.
  - A default WIDTH constant.
- One natural sub-module: dff_ar_n, a WIDTH-parameterised enabled flop with async active-low clear. It is used for out_q and, when enabled, par_q.

Test Plan:
- Exhaustive combinational sweep, WIDTH=1: for i=0..63 set {d3,d2,d1,d0,s1,s0}=i, wait 5 ns, check out = d[{s1,s0}].
  - Example: i=6'b100011 (d3=1, d2=0, d1=0, d0=0, s1=1, s0=1) → out=1.
- Reset: rst_n=0 with d0=1, sel=00, en=1 → out_q=0 immediately, out=1. Release rst_n → after next edge out_q=1.
- Enable hold: load out_q=1 (d2=1, sel=10). Then set en=0, d2=0 → out=0, out_q stays 1 for 3 edges. Set en=1 → out_q=0 after 1 edge.
- Async reset mid-cycle: out_q=1, pulse rst_n low between clock edges → out_q drops to 0 without a clock edge.
- Same-cycle change, WIDTH=8: d1=8'hA5, d3=8'h3C; switch sel 01→11 in the cycle before an edge → out=8'h3C, out_q=8'h3C after the edge.
- Parity build with MUX4_TO_1_PARITY_EN defined, WIDTH=8: d0=8'h07, sel=00, en=1 → out_q=8'h07, par_q=1 after 1 edge. d0=8'h03 → par_q=0.

Source files
------------

// File: rtl/mux4_to_1_pkg.sv
// Shared select encodings and default width for the 4-to-1 selector.
package mux4_to_1_pkg;

  localparam int DEFAULT_WIDTH = 1;

  typedef enum logic [1:0] {
    SEL_D0 = 2'b00,
    SEL_D1 = 2'b01,
    SEL_D2 = 2'b10,
    SEL_D3 = 2'b11
  } sel_e;

endpackage

// File: rtl/mux4_to_1_dff_ar_n.sv
// Enabled flop bank with asynchronous active-low clear.
// Latency 1 cycle when en is high; holds otherwise; no backpressure.
module dff_ar_n
  import mux4_to_1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mux4_to_1.sv
// 4-to-1 selector: out is combinational (0 cycles), out_q registered under en (1 cycle); no backpressure.
// Optional par_q (even parity of the loaded word) is enabled with MUX4_TO_1_PARITY_EN.
module mux4_to_1
  import mux4_to_1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             s0,
  input  logic             s1,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
`ifdef MUX4_TO_1_PARITY_EN
  ,
  output logic             par_q
`endif
);

  logic [1:0] sel;

  assign sel = {s1, s0};

  // An unknown select matches no item, so out goes X rather than favouring any input.
  always_comb begin
    out = 'x;
    case (sel)
      SEL_D0:  out = d0;
      SEL_D1:  out = d1;
      SEL_D2:  out = d2;
      SEL_D3:  out = d3;
      default: out = 'x;
    endcase
  end

  dff_ar_n #(
    .WIDTH (WIDTH)
  ) u_data_q (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .d     (out),
    .q     (out_q)
  );

`ifdef MUX4_TO_1_PARITY_EN
  logic par_d;

  assign par_d = ^out;

  dff_ar_n #(
    .WIDTH (1)
  ) u_par_q (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .d     (par_d),
    .q     (par_q)
  );
`endif

endmodule

// File: tb/tb_mux4_to_1.sv
// Self-checking bench for mux4_to_1 at WIDTH=1 and WIDTH=8 against a behavioural model.
module tb_mux4_to_1;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       s0;
  logic       s1;
  logic       a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;
  logic       out1, outq1;
  logic [7:0] out8, outq8;
  logic       par1, par8;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model state: what the registered outputs must hold
  logic       exp_q1;
  logic [7:0] exp_q8;

  mux4_to_1 #(.WIDTH(1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .d0    (a0),
    .d1    (a1),
    .d2    (a2),
    .d3    (a3),
    .s0    (s0),
    .s1    (s1),
    .en    (en),
    .out   (out1),
    .out_q (outq1)
`ifdef MUX4_TO_1_PARITY_EN
    ,
    .par_q (par1)
`endif
  );

  mux4_to_1 #(.WIDTH(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .d0    (b0),
    .d1    (b1),
    .d2    (b2),
    .d3    (b3),
    .s0    (s0),
    .s1    (s1),
    .en    (en),
    .out   (out8),
    .out_q (outq8)
`ifdef MUX4_TO_1_PARITY_EN
    ,
    .par_q (par8)
`endif
  );

`ifndef MUX4_TO_1_PARITY_EN
  assign par1 = 1'b0;
  assign par8 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pick(input int sel, input logic [7:0] x0, input logic [7:0] x1,
                                      input logic [7:0] x2, input logic [7:0] x3);
    logic [7:0] v [4];
    v[0] = x0; v[1] = x1; v[2] = x2; v[3] = x3;
    return v[sel];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q1 <= 1'b0;
      exp_q8 <= 8'h00;
    end else if (en) begin
      exp_q1 <= pick(int'({s1, s0}), {7'd0, a0}, {7'd0, a1}, {7'd0, a2}, {7'd0, a3}) != 8'd0;
      exp_q8 <= pick(int'({s1, s0}), b0, b1, b2, b3);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_w1", 32'(out1),
          32'(pick(int'({s1, s0}), {7'd0, a0}, {7'd0, a1}, {7'd0, a2}, {7'd0, a3})));
      chk("out_w8", 32'(out8), 32'(pick(int'({s1, s0}), b0, b1, b2, b3)));
      chk("out_q_w1", 32'(outq1), 32'(exp_q1));
      chk("out_q_w8", 32'(outq8), 32'(exp_q8));
`ifdef MUX4_TO_1_PARITY_EN
      chk("par_q_w1", 32'(par1), 32'(^exp_q1));
      chk("par_q_w8", 32'(par8), 32'(^exp_q8));
`endif
    end
  end

  // Inputs change 1 ns after each rising edge, well clear of both edges
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] v;
    rst_n = 1'b0; en = 1'b0; s0 = 1'b0; s1 = 1'b0;
    a0 = 1'b0; a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
    b0 = 8'h00; b1 = 8'h00; b2 = 8'h00; b3 = 8'h00;
    tick();

    // Reset holds out_q at zero even with en and a live select
    a0 = 1'b1; b0 = 8'h5A; en = 1'b1;
    #1;
    chk("rst_out", 32'(out1), 32'd1);
    chk("rst_out_q", 32'(outq1), 32'd0);
    tick();
    chk("rst_held_out_q", 32'(outq1), 32'd0);
    chk("rst_held_out_q8", 32'(outq8), 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();
    chk("first_load", 32'(outq1), 32'd1);
    chk("first_load8", 32'(outq8), 32'h5A);

    // Enable hold
    a2 = 1'b1; b2 = 8'hC3; s1 = 1'b1; s0 = 1'b0;
    tick();
    chk("load_d2", 32'(outq1), 32'd1);
    en = 1'b0; a2 = 1'b0; b2 = 8'h11;
    #1;
    chk("hold_out", 32'(out1), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_out_q", 32'(outq1), 32'd1);
      chk("hold_out_q8", 32'(outq8), 32'hC3);
    end
    en = 1'b1;
    tick();
    chk("reload_out_q", 32'(outq1), 32'd0);
    chk("reload_out_q8", 32'(outq8), 32'h11);

    // Asynchronous reset between edges
    a2 = 1'b1;
    tick();
    chk("pre_async", 32'(outq1), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_clr", 32'(outq1), 32'd0);
    chk("async_clr8", 32'(outq8), 32'd0);
    chk("async_out_live", 32'(out1), 32'd1);
    #1 rst_n = 1'b1;

    // Select and data change together ahead of an edge
    b1 = 8'hA5; b3 = 8'h3C; s1 = 1'b0; s0 = 1'b1;
    tick();
    chk("same_cyc_a5", 32'(outq8), 32'hA5);
    s1 = 1'b1; s0 = 1'b1;
    #1;
    chk("same_cyc_out", 32'(out8), 32'h3C);
    tick();
    chk("same_cyc_out_q", 32'(outq8), 32'h3C);

`ifdef MUX4_TO_1_PARITY_EN
    b0 = 8'h07; s1 = 1'b0; s0 = 1'b0;
    tick();
    chk("par_07_q", 32'(outq8), 32'h07);
    chk("par_07", 32'(par8), 32'd1);
    b0 = 8'h03;
    tick();
    chk("par_03", 32'(par8), 32'd0);
`endif

    // Exhaustive WIDTH=1 sweep: {d3,d2,d1,d0,s1,s0} = i
    for (int i = 0; i < 64; i++) begin
      tick();
      v = i[5:0];
      {a3, a2, a1, a0, s1, s0} = v;
      #1;
      chk("sweep", 32'(out1), (i >> (2 + (i % 4))) & 1);
      if (i == 35) chk("sweep_example", 32'(out1), 32'd1);
    end

    // Randomized traffic, including occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      tick();
      {a3, a2, a1, a0} = 4'($urandom);
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      {s1, s0} = 2'($urandom);
      en = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 31) != 0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
